// File: rtl/bs_ckpt_pkg.sv
// Shared constants for the branch checkpoint buffer in the rename stage.
// Module parameters take their defaults from here so every file agrees on sizes.
package bs_ckpt_pkg;

   localparam int CKPT_DEPTH = 8;
   localparam int CKPT_TAGW  = 3;
   localparam int PRW        = 5;

   localparam logic [4:0] ZERO_REG_5 = 5'd0;

   // Width needed to hold a count from 0 up to n inclusive.
   function automatic int countWidth(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bs_ckpt_if.sv
// Dispatch, resolve and recovery signals of the checkpoint buffer, bundled.
// The master side is the rename/dispatch logic; the slave side is the buffer itself.
interface bs_ckpt_if #(
   parameter int WAYS = 2,
   parameter int PRW  = bs_ckpt_pkg::PRW,
   parameter int TAGW = bs_ckpt_pkg::CKPT_TAGW
);

   logic [WAYS-1:0]      disp_valid;
   logic [WAYS-1:0]      disp_branch;
   logic [WAYS-1:0]      disp_dest_zero;
   logic [PRW-1:0]       fl_head_in;
   logic [WAYS*TAGW-1:0] ckpt_tag_out;
   logic                 ckpt_full;
   logic                 resolve_valid;
   logic [TAGW-1:0]      resolve_tag;
   logic                 resolve_mispredict;
   logic                 recover_valid;
   logic [PRW-1:0]       recover_fl_head;
   logic [TAGW:0]        count;

   modport master (
      output disp_valid, disp_branch, disp_dest_zero, fl_head_in,
             resolve_valid, resolve_tag, resolve_mispredict,
      input  ckpt_tag_out, ckpt_full, recover_valid, recover_fl_head, count
   );

   modport slave (
      input  disp_valid, disp_branch, disp_dest_zero, fl_head_in,
             resolve_valid, resolve_tag, resolve_mispredict,
      output ckpt_tag_out, ckpt_full, recover_valid, recover_fl_head, count
   );

endinterface

// File: rtl/bs_ckpt_prefix.sv
// Per-lane running counts across the dispatch bundle: allocating branches in
// older lanes (for tags) and free-list consumers up to and including each lane.
module bs_ckpt_prefix #(
   parameter int WAYS = 2,
   parameter int CW   = $clog2(WAYS + 1)
) (
   input  logic [WAYS-1:0]         laneAlloc,
   input  logic [WAYS-1:0]         laneDest,
   output logic [WAYS-1:0][CW-1:0] allocBefore,
   output logic [WAYS-1:0][CW-1:0] destUpTo,
   output logic [CW-1:0]           allocTotal
);

   logic [CW-1:0] allocRun;
   logic [CW-1:0] destRun;

   // allocBefore excludes the lane itself, destUpTo includes it, because a
   // branch's own destination is already consumed when its snapshot is taken.
   always_comb begin
      allocRun    = '0;
      destRun     = '0;
      allocBefore = '0;
      destUpTo    = '0;
      for (int k = 0; k < WAYS; k++) begin
         allocBefore[k] = allocRun;
         if (laneAlloc[k]) allocRun = allocRun + CW'(1);
         if (laneDest[k])  destRun  = destRun + CW'(1);
         destUpTo[k] = destRun;
      end
      allocTotal = allocRun;
   end

endmodule

// File: rtl/bs_ckpt.sv
// Branch checkpoint buffer: allocates tags to dispatched branches, snapshots the
// free-list head after each, retires in order and rolls back on a mispredict.
module bs_ckpt #(
   parameter int WAYS  = 2,
   parameter int DEPTH = bs_ckpt_pkg::CKPT_DEPTH,
   parameter int PRW   = bs_ckpt_pkg::PRW,
   parameter int TAGW  = bs_ckpt_pkg::CKPT_TAGW
) (
   input logic      clock,
   input logic      reset,
   bs_ckpt_if.slave bus
);

   import bs_ckpt_pkg::*;

   localparam int CW = $clog2(WAYS + 1);
   localparam int PW = TAGW + 1;

   logic [PW-1:0]             headPtr;
   logic [PW-1:0]             tailPtr;
   logic [DEPTH-1:0]          entryValid;
   logic [DEPTH-1:0]          entryResolved;
   logic [PRW-1:0]            snapshot [DEPTH];
   logic                      recoverValid;
   logic [PRW-1:0]            recoverFlHead;

   logic [WAYS-1:0]           laneAlloc;
   logic [WAYS-1:0]           laneDest;
   logic [WAYS-1:0][CW-1:0]   allocBefore;
   logic [WAYS-1:0][CW-1:0]   destUpTo;
   logic [CW-1:0]             allocTotal;
   logic [WAYS-1:0][TAGW-1:0] laneTag;
   logic [WAYS-1:0][PRW-1:0]  laneSnap;

   logic [PW-1:0]             occupancy;
   logic                      full;
   logic                      mispredict;
   logic                      correctResolve;
   logic                      allocEn;
   logic [TAGW-1:0]           headIdx;
   logic [TAGW-1:0]           tailIdx;
   logic [TAGW-1:0]           squashOffset;
   logic [DEPTH-1:0]          resolvedEff;
   logic [DEPTH-1:0]          retireMask;
   logic [DEPTH-1:0]          squashMask;
   logic [PW-1:0]             retireCnt;
   logic [TAGW-1:0]           retireIdx;
   logic                      retireStop;

   assign laneAlloc = bus.disp_valid & bus.disp_branch;
   assign laneDest  = bus.disp_valid & ~bus.disp_dest_zero;

   bs_ckpt_prefix #(.WAYS(WAYS), .CW(CW)) prefix (
      .laneAlloc  (laneAlloc),
      .laneDest   (laneDest),
      .allocBefore(allocBefore),
      .destUpTo   (destUpTo),
      .allocTotal (allocTotal)
   );

   assign headIdx        = headPtr[TAGW-1:0];
   assign tailIdx        = tailPtr[TAGW-1:0];
   assign occupancy      = tailPtr - headPtr;
   assign full           = occupancy > PW'(DEPTH - WAYS);
   assign mispredict     = bus.resolve_valid & bus.resolve_mispredict & entryValid[bus.resolve_tag];
   assign correctResolve = bus.resolve_valid & ~bus.resolve_mispredict & entryValid[bus.resolve_tag];
   assign allocEn        = ~full & ~mispredict;
   assign squashOffset   = bus.resolve_tag - headIdx;

   always_comb begin
      laneTag  = '0;
      laneSnap = '0;
      for (int k = 0; k < WAYS; k++) begin
         laneTag[k]  = tailIdx + TAGW'(allocBefore[k]);
         laneSnap[k] = bus.fl_head_in + PRW'(destUpTo[k]);
      end
   end

   // A correct resolve arriving this cycle counts immediately, so a head
   // branch resolving now retires on this edge together with any already
   // resolved successors.
   always_comb begin
      resolvedEff = entryResolved;
      if (correctResolve) resolvedEff[bus.resolve_tag] = 1'b1;
      retireMask = '0;
      retireCnt  = '0;
      retireStop = 1'b0;
      retireIdx  = headIdx;
      for (int i = 0; i < DEPTH; i++) begin
         retireIdx = headIdx + TAGW'(i);
         if (!retireStop && entryValid[retireIdx] && resolvedEff[retireIdx]) begin
            retireMask[retireIdx] = 1'b1;
            retireCnt             = retireCnt + PW'(1);
         end else begin
            retireStop = 1'b1;
         end
      end
   end

   // Age is the distance from head; everything at least as young as the
   // mispredicted branch goes.
   always_comb begin
      squashMask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         squashMask[i] = mispredict && ((TAGW'(i) - headIdx) >= squashOffset);
      end
   end

   // Pointer, valid/resolved and recovery state.
   always_ff @(posedge clock) begin
      if (reset) begin
         headPtr       <= '0;
         tailPtr       <= '0;
         entryValid    <= '0;
         entryResolved <= '0;
         recoverValid  <= 1'b0;
         recoverFlHead <= '0;
      end else begin
         recoverValid <= mispredict;
         if (mispredict) recoverFlHead <= snapshot[bus.resolve_tag];
         headPtr <= headPtr + retireCnt;
         for (int i = 0; i < DEPTH; i++) begin
            if (retireMask[i] || squashMask[i]) begin
               entryValid[i]    <= 1'b0;
               entryResolved[i] <= 1'b0;
            end else if (correctResolve && bus.resolve_tag == TAGW'(i)) begin
               entryResolved[i] <= 1'b1;
            end
         end
         if (mispredict) begin
            tailPtr <= headPtr + PW'(squashOffset);
         end else if (allocEn) begin
            tailPtr <= tailPtr + PW'(allocTotal);
            for (int k = 0; k < WAYS; k++) begin
               if (laneAlloc[k]) begin
                  entryValid[laneTag[k]]    <= 1'b1;
                  entryResolved[laneTag[k]] <= 1'b0;
               end
            end
         end
      end
   end

   // Snapshot payload only matters while its entry is valid, so it is not reset.
   always_ff @(posedge clock) begin
      if (allocEn) begin
         for (int k = 0; k < WAYS; k++) begin
            if (laneAlloc[k]) snapshot[laneTag[k]] <= laneSnap[k];
         end
      end
   end

   assign bus.ckpt_tag_out    = laneTag;
   assign bus.ckpt_full       = full;
   assign bus.count           = occupancy;
   assign bus.recover_valid   = recoverValid;
   assign bus.recover_fl_head = recoverFlHead;

endmodule

// File: tb/tb_bs_ckpt.sv
// Directed bench for bs_ckpt: allocation, snapshots, in-order retire, squash,
// full stall, reset mid-operation and tag wrap, with hand-computed expectations.
module tb_bs_ckpt;

   logic clock = 1'b0;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;
   logic [2:0] expTag;

   bs_ckpt_if #(.WAYS(2), .PRW(5), .TAGW(3)) bus ();

   bs_ckpt #(.WAYS(2), .DEPTH(8), .PRW(5), .TAGW(3)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] b, input logic [1:0] dz,
                                input logic [4:0] fl, input logic rv, input logic [2:0] rt,
                                input logic rm);
      bus.disp_valid         = v;
      bus.disp_branch        = b;
      bus.disp_dest_zero     = dz;
      bus.fl_head_in         = fl;
      bus.resolve_valid      = rv;
      bus.resolve_tag        = rt;
      bus.resolve_mispredict = rm;
      #1;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      step();
      reset = 1'b0;
      checkOutput("reset_count", 32'(bus.count), 32'd0);
      checkOutput("reset_full", 32'(bus.ckpt_full), 32'd0);
      checkOutput("reset_recover_valid", 32'(bus.recover_valid), 32'd0);
      checkOutput("reset_recover_head", 32'(bus.recover_fl_head), 32'd0);

      $display("[TB] single branch, mispredict");
      applyStimulus(2'b01, 2'b01, 2'b00, 5'd7, 1'b0, 3'd0, 1'b0);
      checkOutput("t1_tag0", 32'(bus.ckpt_tag_out[2:0]), 32'd0);
      step();
      checkOutput("t1_count", 32'(bus.count), 32'd1);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd0, 1'b1);
      step();
      checkOutput("t1_recover_valid", 32'(bus.recover_valid), 32'd1);
      checkOutput("t1_recover_head", 32'(bus.recover_fl_head), 32'd8);
      checkOutput("t1_count_after", 32'(bus.count), 32'd0);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t1_recover_pulse_end", 32'(bus.recover_valid), 32'd0);
      checkOutput("t1_recover_head_hold", 32'(bus.recover_fl_head), 32'd8);

      $display("[TB] two lanes, snapshot wrap");
      applyStimulus(2'b11, 2'b11, 2'b01, 5'd31, 1'b0, 3'd0, 1'b0);
      checkOutput("t2_tags", 32'(bus.ckpt_tag_out), 32'd8);
      step();
      checkOutput("t2_count", 32'(bus.count), 32'd2);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd1, 1'b1);
      step();
      checkOutput("t2_recover_valid", 32'(bus.recover_valid), 32'd1);
      checkOutput("t2_recover_head_wrap", 32'(bus.recover_fl_head), 32'd0);
      checkOutput("t2_count_after", 32'(bus.count), 32'd1);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd0, 1'b1);
      step();
      checkOutput("t2_recover_head_lane0", 32'(bus.recover_fl_head), 32'd31);
      checkOutput("t2_count_empty", 32'(bus.count), 32'd0);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();

      $display("[TB] out-of-order resolve, in-order retire");
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd10, 1'b0, 3'd0, 1'b0);
      step();
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd12, 1'b0, 3'd0, 1'b0);
      checkOutput("t3_tags23", 32'(bus.ckpt_tag_out), 32'd26);
      step();
      checkOutput("t3_count4", 32'(bus.count), 32'd4);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd2, 1'b0);
      step();
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd1, 1'b0);
      step();
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t3_head_blocked", 32'(bus.count), 32'd4);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd0, 1'b0);
      step();
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t3_multi_retire", 32'(bus.count), 32'd1);
      checkOutput("t3_no_recover", 32'(bus.recover_valid), 32'd0);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd3, 1'b0);
      step();
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t3_drained", 32'(bus.count), 32'd0);

      $display("[TB] fill to full");
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      checkOutput("t4_tags45", 32'(bus.ckpt_tag_out), 32'd44);
      step();
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t4_count6", 32'(bus.count), 32'd6);
      checkOutput("t4_not_full_at6", 32'(bus.ckpt_full), 32'd0);
      applyStimulus(2'b01, 2'b01, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t4_count7", 32'(bus.count), 32'd7);
      checkOutput("t4_full_at7", 32'(bus.ckpt_full), 32'd1);
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t4_stalled_count", 32'(bus.count), 32'd7);

      $display("[TB] reset mid-operation");
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("t4r_count", 32'(bus.count), 32'd0);
      checkOutput("t4r_full", 32'(bus.ckpt_full), 32'd0);
      checkOutput("t4r_recover_valid", 32'(bus.recover_valid), 32'd0);
      checkOutput("t4r_recover_head", 32'(bus.recover_fl_head), 32'd0);

      $display("[TB] squash younger with same-cycle dispatch");
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd2, 1'b0, 3'd0, 1'b0);
      step();
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd5, 1'b0, 3'd0, 1'b0);
      step();
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd9, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t5_count6", 32'(bus.count), 32'd6);
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd20, 1'b1, 3'd2, 1'b1);
      step();
      checkOutput("t5_recover_valid", 32'(bus.recover_valid), 32'd1);
      checkOutput("t5_recover_head", 32'(bus.recover_fl_head), 32'd6);
      checkOutput("t5_count2", 32'(bus.count), 32'd2);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOutput("t5_single_pulse", 32'(bus.recover_valid), 32'd0);
      checkOutput("t5_count_dropped", 32'(bus.count), 32'd2);
      applyStimulus(2'b01, 2'b01, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      checkOutput("t5_tail_tag", 32'(bus.ckpt_tag_out[2:0]), 32'd2);
      step();
      checkOutput("t5_count3", 32'(bus.count), 32'd3);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd0, 1'b0);
      step();
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, 3'd1, 1'b1);
      step();
      checkOutput("t5_retire_and_squash", 32'(bus.count), 32'd0);
      checkOutput("t5_recover_head_tag1", 32'(bus.recover_fl_head), 32'd4);
      applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
      step();

      $display("[TB] allocate/resolve pairs with tag wrap");
      expTag = 3'd1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(2'b01, 2'b01, 2'b00, 5'(i), 1'b0, 3'd0, 1'b0);
         checkOutput("t6_tag", 32'(bus.ckpt_tag_out[2:0]), 32'(expTag));
         step();
         checkOutput("t6_count_alloc", 32'(bus.count), 32'd1);
         applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b1, expTag, 1'b0);
         step();
         checkOutput("t6_no_recover", 32'(bus.recover_valid), 32'd0);
         applyStimulus(2'b00, 2'b00, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
         step();
         checkOutput("t6_count_retired", 32'(bus.count), 32'd0);
         expTag = expTag + 3'd1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bs_ckpt.md
Name: bs_ckpt

Overview:
- Parametrised branch checkpoint buffer for the rename stage.
- Supports WAYS dispatch lanes. Each dispatched branch is allocated a checkpoint tag, and the buffer snapshots the free-list head that follows that branch.
- On a mispredicted resolve, the buffer returns the snapshot for free-list rollback and squashes all younger checkpoints.
- Entries are freed in order once resolved correctly.

Parameters:
- WAYS, 2, number of dispatch lanes per cycle.
- DEPTH, 8, number of checkpoint entries (power of 2, DEPTH >= WAYS).
- PRW, 5, free-list head pointer width.
- TAGW, 3, checkpoint tag width (= log2 DEPTH).

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- disp_valid  in  WAYS  lane k holds a valid instruction
- disp_branch  in  WAYS  lane k is a conditional or unconditional branch
- disp_dest_zero  in  WAYS  lane k writes the zero register, so it takes no free-list entry
- fl_head_in  in  PRW  current free-list head before this bundle
- ckpt_tag_out  out  WAYS*TAGW  tag allocated to lane k; lane k occupies bits [k*TAGW +: TAGW]
- ckpt_full  out  1  dispatch must stall
- resolve_valid  in  1  a branch resolves this cycle
- resolve_tag  in  TAGW  tag of the resolving branch
- resolve_mispredict  in  1  the resolving branch mispredicted
- recover_valid  out  1  one-cycle pulse: roll back the free list
- recover_fl_head  out  PRW  restored free-list head
- count  out  TAGW+1  number of occupied entries

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. Reset clears all entry valid/resolved bits, head=tail=0, count=0, recover_valid=0, recover_fl_head=0. Reset mid-operation discards all checkpoints with no recover pulse.
- ckpt_full = (count > DEPTH-WAYS). This is combinational from registered state only.
- Allocation:
  - Active only when ~ckpt_full and there is no mispredict this cycle.
  - A lane allocates when disp_valid & disp_branch.
  - Lane k tag = tail + number of allocating lanes j<k, modulo DEPTH.
  - ckpt_tag_out is combinational and valid in the dispatch cycle; it is don't-care for non-allocating lanes.
  - tail advances by the number of allocations.
- Snapshot value for lane k:
  - fl_head_in + number of lanes j<=k with disp_valid & ~disp_dest_zero.
  - Computed modulo 2^PRW, so it wraps at 2^PRW-1 -> 0.
  - A branch's own destination counts toward its snapshot.
- Correct resolve (resolve_valid & ~resolve_mispredict, entry valid):
  - Marks the entry resolved.
  - Each cycle, head retires consecutive valid+resolved entries (up to DEPTH) starting at head, clearing their valid bits.
  - A resolve to an invalid tag is ignored.
- Mispredict resolve (entry valid):
  - Next cycle: recover_valid=1 and recover_fl_head = snapshot[resolve_tag].
  - Entry resolve_tag and all younger entries (resolve_tag .. tail-1, circular) are invalidated; tail <= resolve_tag.
  - Same-cycle dispatch allocations are dropped.
  - Same-cycle head retirement of entries older than resolve_tag still occurs.
- recover_valid is high for exactly one cycle per mispredict and 0 otherwise. recover_fl_head holds its last value.
- count = tail - head (with a wrap bit). It is updated at the clock edge after alloc/retire/squash; all three may occur in the same cycle.
- Full: allocation when count=DEPTH is impossible by construction, because ckpt_full blocks it.
- Empty: retirement stops at tail.
- Wrap-around: head, tail and tags wrap modulo DEPTH; a TAGW+1-bit pointer distinguishes full from empty.

Decomposition:
- Shared package holds CKPT_DEPTH, CKPT_TAGW, PRW and the ZERO_REG_5 constant.
- Sub-module bs_ckpt_prefix: a combinational per-lane prefix count of allocations and dest-consumers, used for both tags and snapshots.

Test Plan:
- Reset, then a single branch on lane0 with dest, fl_head_in=7 -> tag 0; mispredict tag 0 -> next cycle recover_valid=1, recover_fl_head=8, count=0.
- Lane0 branch with dest_zero, lane1 branch with dest, fl_head_in=31 -> tags 0,1; snapshots 31 and 0 (wrap); mispredict tag1 -> recover_fl_head=0, count=1.
- Allocate tags 0..3, resolve tags 2 and 1 correct, then tag 0 correct -> head advances 0->3 in one cycle, count=1.
- Fill to count=7 with WAYS=2 -> ckpt_full=1; a dispatched branch is not allocated and tail is unchanged.
- Mispredict tag 2 with tags 0..5 live plus a same-cycle dispatch branch -> tail=2, count=2, dispatch dropped, single recover pulse.
- Run 20 allocate/correct-resolve pairs -> tags wrap 7->0, count never exceeds 8, recover_valid never asserts.
